// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: decode-stage operands, register IDs, ALU function and
// WB/M/EX control bundles are delayed by exactly one clock toward the execute stage.
module id_ex_reg #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4,
   parameter int PC_W   = 2,
   parameter int EX_W   = 3,
   parameter int M_W    = 3,
   parameter int WB_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] shiftIn,
   input  logic [PC_W-1:0]   pcIn,
   input  logic [DATA_W-1:0] addIn,
   input  logic [DATA_W-1:0] readDataIn1,
   input  logic [DATA_W-1:0] readDataIn2,
   input  logic [REG_W-1:0]  ALUfuncIn,
   input  logic [REG_W-1:0]  readRegIn1,
   input  logic [REG_W-1:0]  readRegIn2,
   input  logic [EX_W-1:0]   exIn,
   input  logic [M_W-1:0]    mIn,
   input  logic [WB_W-1:0]   wbIn,
   output logic [DATA_W-1:0] shiftOut,
   output logic [PC_W-1:0]   pcOut,
   output logic [DATA_W-1:0] addOut,
   output logic [DATA_W-1:0] readDataOut1,
   output logic [DATA_W-1:0] readDataOut2,
   output logic [REG_W-1:0]  ALUfuncOut,
   output logic [REG_W-1:0]  readRegOut1,
   output logic [REG_W-1:0]  readRegOut2,
   output logic [EX_W-1:0]   exOut,
   output logic [M_W-1:0]    mOut,
   output logic [WB_W-1:0]   wbOut
);

   logic [DATA_W-1:0] r_shift;
   logic [PC_W-1:0]   r_pc;
   logic [DATA_W-1:0] r_add;
   logic [DATA_W-1:0] r_read_data1;
   logic [DATA_W-1:0] r_read_data2;
   logic [REG_W-1:0]  r_alu_func;
   logic [REG_W-1:0]  r_read_reg1;
   logic [REG_W-1:0]  r_read_reg2;
   logic [EX_W-1:0]   r_ex;
   logic [M_W-1:0]    r_m;
   logic [WB_W-1:0]   r_wb;

   // Bubbles come from upstream zeroing the control inputs; there is no hold or flush here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift      <= '0;
         r_pc         <= '0;
         r_add        <= '0;
         r_read_data1 <= '0;
         r_read_data2 <= '0;
         r_alu_func   <= '0;
         r_read_reg1  <= '0;
         r_read_reg2  <= '0;
         r_ex         <= '0;
         r_m          <= '0;
         r_wb         <= '0;
      end else begin
         r_shift      <= shiftIn;
         r_pc         <= pcIn;
         r_add        <= addIn;
         r_read_data1 <= readDataIn1;
         r_read_data2 <= readDataIn2;
         r_alu_func   <= ALUfuncIn;
         r_read_reg1  <= readRegIn1;
         r_read_reg2  <= readRegIn2;
         r_ex         <= exIn;
         r_m          <= mIn;
         r_wb         <= wbIn;
      end
   end

   assign shiftOut     = r_shift;
   assign pcOut        = r_pc;
   assign addOut       = r_add;
   assign readDataOut1 = r_read_data1;
   assign readDataOut2 = r_read_data2;
   assign ALUfuncOut   = r_alu_func;
   assign readRegOut1  = r_read_reg1;
   assign readRegOut2  = r_read_reg2;
   assign exOut        = r_ex;
   assign mOut         = r_m;
   assign wbOut        = r_wb;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, capture, async reset pulse, no-comb-path and
// walking-one cross-wiring checks on the full 86-bit field bundle.
module tb_id_ex_reg;

   localparam int BUS_W = 86;
   // Field order: shift, pc, add, rd1, rd2, alu, rr1, rr2, ex, m, wb
   localparam logic [BUS_W-1:0] VEC3 = {16'h1234, 2'b01, 16'h1122, 16'h0000, 16'h1111,
                                        4'h8, 4'h3, 4'hA, 3'b001, 3'b000, 2'b01};
   localparam logic [BUS_W-1:0] VEC5 = {16'hBEEF, 2'b10, 16'h5A5A, 16'hC3C3, 16'h0F0F,
                                        4'h6, 4'hC, 4'h1, 3'b110, 3'b101, 2'b10};

   logic clk;
   logic rst;
   logic [BUS_W-1:0] in_bus;
   logic [BUS_W-1:0] out_bus;

   logic [15:0] shiftIn, addIn, readDataIn1, readDataIn2;
   logic [1:0]  pcIn, wbIn;
   logic [3:0]  ALUfuncIn, readRegIn1, readRegIn2;
   logic [2:0]  exIn, mIn;
   logic [15:0] shiftOut, addOut, readDataOut1, readDataOut2;
   logic [1:0]  pcOut, wbOut;
   logic [3:0]  ALUfuncOut, readRegOut1, readRegOut2;
   logic [2:0]  exOut, mOut;

   int n_pass;
   int n_total;

   assign {shiftIn, pcIn, addIn, readDataIn1, readDataIn2, ALUfuncIn,
           readRegIn1, readRegIn2, exIn, mIn, wbIn} = in_bus;
   assign out_bus = {shiftOut, pcOut, addOut, readDataOut1, readDataOut2, ALUfuncOut,
                     readRegOut1, readRegOut2, exOut, mOut, wbOut};

   id_ex_reg dut (
      .clk(clk), .rst(rst),
      .shiftIn(shiftIn), .pcIn(pcIn), .addIn(addIn),
      .readDataIn1(readDataIn1), .readDataIn2(readDataIn2),
      .ALUfuncIn(ALUfuncIn), .readRegIn1(readRegIn1), .readRegIn2(readRegIn2),
      .exIn(exIn), .mIn(mIn), .wbIn(wbIn),
      .shiftOut(shiftOut), .pcOut(pcOut), .addOut(addOut),
      .readDataOut1(readDataOut1), .readDataOut2(readDataOut2),
      .ALUfuncOut(ALUfuncOut), .readRegOut1(readRegOut1), .readRegOut2(readRegOut2),
      .exOut(exOut), .mOut(mOut), .wbOut(wbOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b0;
      in_bus = 'x;
      #1;
      n_total++;
      if (out_bus !== '0) $display("FAIL reset_initial: got %h expected 0", out_bus);
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         n_total++;
         if (out_bus !== '0) $display("FAIL reset_hold edge%0d: got %h expected 0", k, out_bus);
         else n_pass++;
      end
   endtask

   task automatic test_all_ones();
      rst = 1'b1;
      in_bus = '1;
      #1;
      n_total++;
      if (out_bus !== '0) $display("FAIL ones_before_edge: got %h expected 0", out_bus);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (out_bus !== {BUS_W{1'b1}}) $display("FAIL ones_after_edge: got %h expected all ones", out_bus);
      else n_pass++;
   endtask

   task automatic test_vector();
      in_bus = VEC3;
      @(posedge clk); #1;
      n_total++;
      if (out_bus !== VEC3) $display("FAIL vector_capture: got %h expected %h", out_bus, VEC3);
      else n_pass++;
      n_total++;
      if (shiftOut !== 16'h1234 || readRegOut2 !== 4'hA || exOut !== 3'b001 || wbOut !== 2'b01)
         $display("FAIL vector_fields: shift %h rr2 %h ex %b wb %b expected 1234 a 001 01",
                  shiftOut, readRegOut2, exOut, wbOut);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      // Entered 1 ns after a rising edge with VEC3 held and already captured.
      #1 rst = 1'b0;
      #1;
      n_total++;
      if (out_bus !== '0) $display("FAIL async_clear: got %h expected 0", out_bus);
      else n_pass++;
      #4 rst = 1'b1;
      #1;
      n_total++;
      if (out_bus !== '0) $display("FAIL release_hold: got %h expected 0", out_bus);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (out_bus !== VEC3) $display("FAIL release_capture: got %h expected %h", out_bus, VEC3);
      else n_pass++;
   endtask

   task automatic test_no_comb_path();
      in_bus = VEC5;
      #3;
      n_total++;
      if (out_bus !== VEC3) $display("FAIL no_comb_path: got %h expected %h", out_bus, VEC3);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (out_bus !== VEC5) $display("FAIL new_capture: got %h expected %h", out_bus, VEC5);
      else n_pass++;
   endtask

   task automatic test_walking_one();
      logic [BUS_W-1:0] prev;
      logic [BUS_W-1:0] cur;
      in_bus = '0;
      @(posedge clk); #1;
      n_total++;
      if (out_bus !== '0) $display("FAIL walk_zero: got %h expected 0", out_bus);
      else n_pass++;
      prev = '0;
      for (int i = 0; i < BUS_W; i++) begin
         cur = '0;
         cur[i] = 1'b1;
         in_bus = cur;
         #2;
         n_total++;
         if (out_bus !== prev) $display("FAIL walk_hold bit%0d: got %h expected %h", i, out_bus, prev);
         else n_pass++;
         @(posedge clk); #1;
         n_total++;
         if (out_bus !== cur) $display("FAIL walk_capture bit%0d: got %h expected %h", i, out_bus, cur);
         else n_pass++;
         prev = cur;
      end
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_all_ones();
      test_vector();
      test_async_reset();
      test_no_comb_path();
      test_walking_one();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
